phys_bus_bridge: RTL and testbench



---
 rtl/phys_bus_bridge.sv | 172 +++++++++++++++++
 tb/tb_phys_bus_bridge.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/phys_bus_bridge.sv
// phys_bus_bridge: a registered request/response stage that sits between the
// MMU physical port and the system bus interconnect. It captures one access,
// replays it onto the bus from registers, and returns the response. A bus
// watchdog finishes any access whose slave never answers, returning an error
// word and raising a sticky interrupt.
// Optional build: define PHYS_BUS_BRIDGE_BYPASS_EN to replace the stage with
// direct combinational wiring. That build removes the watchdog, the registers
// and the state machine.
module phys_bus_bridge #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter logic [31:0] ERR_WORD       = 32'hdeadbeef
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pa,
   input  logic [31:0] pd,
   input  logic        pwe,
   input  logic        prd,
   output logic [31:0] pspo,
   output logic        pready,
   output logic        pirq,
   input  logic        irq_clr,
   output logic [31:0] a,
   output logic [31:0] d,
   output logic        we,
   output logic        rd,
   input  logic [31:0] spo,
   input  logic        ready,
   output logic [31:0] err_addr
);

`ifdef PHYS_BUS_BRIDGE_BYPASS_EN

   // Straight-through wiring for timing-relaxed builds; no watchdog.
   assign a        = pa;
   assign d        = pd;
   assign we       = pwe;
   assign rd       = prd;
   assign pspo     = spo;
   assign pready   = ready;
   assign pirq     = 1'b0;
   assign err_addr = 32'd0;

   logic unused_bypass;
   assign unused_bypass = ^{clk, rst, irq_clr};

`else

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP,
      S_HOLD
   } state_t;

   // Last counter value that may still see ready before the watchdog fires.
   localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t      state_q, state_d;
   logic [31:0] a_q, a_d;
   logic [31:0] d_q, d_d;
   logic        we_q, we_d;
   logic        rd_q, rd_d;
   logic [31:0] pspo_q, pspo_d;
   logic        pready_q, pready_d;
   logic        pirq_q, pirq_d;
   logic [31:0] err_addr_q, err_addr_d;
   logic [15:0] cnt_q, cnt_d;
   logic        timeout_set;

   // Next-state and next-output logic for the transfer sequence.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned, which would infer a latch.
      state_d     = state_q;
      a_d         = a_q;
      d_d         = d_q;
      we_d        = we_q;
      rd_d        = rd_q;
      pspo_d      = pspo_q;
      pready_d    = 1'b0;
      err_addr_d  = err_addr_q;
      cnt_d       = cnt_q;
      timeout_set = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (prd || pwe) begin
               // A request with both strobes high is treated as a read.
               a_d     = pa;
               d_d     = pd;
               rd_d    = prd;
               we_d    = ~prd;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            cnt_d   = 16'd0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            cnt_d = (cnt_q == 16'hffff) ? cnt_q : cnt_q + 16'd1;
            if (ready) begin
               // A slave answer in the timeout cycle still counts as success.
               pspo_d  = rd_q ? spo : 32'd0;
               rd_d    = 1'b0;
               we_d    = 1'b0;
               state_d = S_RESP;
            end else if (cnt_q == CNT_LAST) begin
               pspo_d      = rd_q ? ERR_WORD : 32'd0;
               err_addr_d  = a_q;
               timeout_set = 1'b1;
               rd_d        = 1'b0;
               we_d        = 1'b0;
               state_d     = S_RESP;
            end
         end
         S_RESP: begin
            pready_d = 1'b1;
            state_d  = S_HOLD;
         end
         S_HOLD: begin
            // The requester still holds its strobe this cycle, so it is ignored.
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // A new timeout outranks a clear that arrives in the same cycle.
      pirq_d = timeout_set ? 1'b1 : (irq_clr ? 1'b0 : pirq_q);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         a_q        <= 32'd0;
         d_q        <= 32'd0;
         we_q       <= 1'b0;
         rd_q       <= 1'b0;
         pspo_q     <= 32'd0;
         pready_q   <= 1'b0;
         pirq_q     <= 1'b0;
         err_addr_q <= 32'd0;
         cnt_q      <= 16'd0;
      end else begin
         // NOTE: clocked state uses non-blocking assignments so every register updates from pre-edge values.
         state_q    <= state_d;
         a_q        <= a_d;
         d_q        <= d_d;
         we_q       <= we_d;
         rd_q       <= rd_d;
         pspo_q     <= pspo_d;
         pready_q   <= pready_d;
         pirq_q     <= pirq_d;
         err_addr_q <= err_addr_d;
         cnt_q      <= cnt_d;
      end
   end

   assign a        = a_q;
   assign d        = d_q;
   assign we       = we_q;
   assign rd       = rd_q;
   assign pspo     = pspo_q;
   assign pready   = pready_q;
   assign pirq     = pirq_q;
   assign err_addr = err_addr_q;

`endif

endmodule

// File: tb/tb_phys_bus_bridge.sv
// Directed bench for phys_bus_bridge. It is built with an 8-cycle watchdog.
module tb_phys_bus_bridge;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pa, pd, spo;
   logic        pwe, prd, irq_clr, ready;
   logic [31:0] pspo, a, d, err_addr;
   logic        pready, pirq, we, rd;

   int n_cmp = 0;
   int n_err = 0;

   // Activity counters, sampled on the rising edge (pre-update values).
   int   n_rd_hi    = 0;
   int   n_rd_rise  = 0;
   int   n_we_rise  = 0;
   int   n_pready   = 0;
   logic rd_prev    = 1'b0;
   logic we_prev    = 1'b0;

   always #5 clk = ~clk;

   phys_bus_bridge #(
      .TIMEOUT_CYCLES(8),
      .ERR_WORD      (32'hdeadbeef)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .pa      (pa),
      .pd      (pd),
      .pwe     (pwe),
      .prd     (prd),
      .pspo    (pspo),
      .pready  (pready),
      .pirq    (pirq),
      .irq_clr (irq_clr),
      .a       (a),
      .d       (d),
      .we      (we),
      .rd      (rd),
      .spo     (spo),
      .ready   (ready),
      .err_addr(err_addr)
   );

   always @(posedge clk) begin
      if (rd) n_rd_hi++;
      if (rd && !rd_prev) n_rd_rise++;
      if (we && !we_prev) n_we_rise++;
      if (pready) n_pready++;
      rd_prev = rd;
      we_prev = we;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Zero-wait read. It starts just after a falling edge with the bridge idle
   // and returns just after the falling edge in the following idle cycle.
   task automatic do_read(input string tag, input logic [31:0] addr,
                          input logic [31:0] data, input logic both);
      pa  = addr;
      pd  = ~data;
      prd = 1'b1;
      pwe = both;
      @(negedge clk);                       // ISSUE
      check({tag, "_issue_a"}, a, addr);
      check({tag, "_issue_rd"}, {31'd0, rd}, 32'd1);
      check({tag, "_issue_we"}, {31'd0, we}, 32'd0);
      @(negedge clk);                       // first WAIT cycle
      ready = 1'b1;
      spo   = data;
      @(negedge clk);                       // RESP
      ready = 1'b0;
      spo   = 32'd0;
      check({tag, "_resp_rd"}, {31'd0, rd}, 32'd0);
      check({tag, "_resp_pready"}, {31'd0, pready}, 32'd0);
      @(negedge clk);                       // HOLD, pready visible
      check({tag, "_pready"}, {31'd0, pready}, 32'd1);
      check({tag, "_pspo"}, pspo, data);
      check({tag, "_pirq"}, {31'd0, pirq}, 32'd0);
      @(negedge clk);                       // IDLE again
      check({tag, "_pready_low"}, {31'd0, pready}, 32'd0);
      prd = 1'b0;
      pwe = 1'b0;
   endtask

   initial begin
      int rd_rise_base;
      int pready_base;

      rst = 1'b1; pa = 32'd0; pd = 32'd0; pwe = 1'b0; prd = 1'b0;
      irq_clr = 1'b0; ready = 1'b0; spo = 32'd0;
      repeat (2) @(negedge clk);

      // Reset state.
      check("rst_pspo", pspo, 32'd0);
      check("rst_pready", {31'd0, pready}, 32'd0);
      check("rst_pirq", {31'd0, pirq}, 32'd0);
      check("rst_a", a, 32'd0);
      check("rst_d", d, 32'd0);
      check("rst_rd_we", {30'd0, rd, we}, 32'd0);
      check("rst_err_addr", err_addr, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Zero-wait read: pready in the fourth cycle after the request edge.
      rd_rise_base = n_rd_rise;
      do_read("rd0", 32'h20000010, 32'h12345678, 1'b0);
      check("rd0_one_access", n_rd_rise - rd_rise_base, 32'd1);

      // Write with ready in the fourth WAIT cycle; HOLD ignores the held pwe.
      n_we_rise = 0;
      pa = 32'h20000004; pd = 32'hcafef00d; pwe = 1'b1;
      @(negedge clk);                       // ISSUE
      check("wr_issue_we", {30'd0, we, rd}, 32'd2);
      for (int i = 0; i < 4; i++) begin     // WAIT cycles 1..4
         @(negedge clk);
         check("wr_wait_a", a, 32'h20000004);
         check("wr_wait_d", d, 32'hcafef00d);
         check("wr_wait_we", {31'd0, we}, 32'd1);
      end
      ready = 1'b1;
      spo   = 32'h55555555;
      @(negedge clk);                       // RESP
      ready = 1'b0;
      check("wr_we_drop", {31'd0, we}, 32'd0);
      @(negedge clk);                       // HOLD
      check("wr_pready", {31'd0, pready}, 32'd1);
      check("wr_pspo", pspo, 32'd0);
      @(negedge clk);                       // IDLE, pwe was still high at HOLD exit
      check("wr_hold_no_access", {30'd0, we, rd}, 32'd0);
      pwe = 1'b0;
      @(negedge clk);
      check("wr_single_access", n_we_rise, 32'd1);
      check("wr_idle_we", {31'd0, we}, 32'd0);

      // Read to a silent slave; irq_clr in the timeout cycle loses to the set.
      n_rd_hi = 0;
      pa = 32'h30000000; prd = 1'b1;
      @(negedge clk);                       // ISSUE
      check("to_issue_rd", {31'd0, rd}, 32'd1);
      repeat (8) @(negedge clk);            // eight WAIT cycles
      check("to_wait_rd", {31'd0, rd}, 32'd1);
      check("to_wait_pirq", {31'd0, pirq}, 32'd0);
      irq_clr = 1'b1;
      @(negedge clk);                       // RESP
      irq_clr = 1'b0;
      check("to_rd_drop", {31'd0, rd}, 32'd0);
      check("to_pirq_set", {31'd0, pirq}, 32'd1);
      check("to_err_addr", err_addr, 32'h30000000);
      @(negedge clk);                       // HOLD
      check("to_pready", {31'd0, pready}, 32'd1);
      check("to_pspo", pspo, 32'hdeadbeef);
      check("to_rd_cycles", n_rd_hi, 32'd9);
      @(negedge clk);
      prd = 1'b0;
      check("to_pirq_sticky", {31'd0, pirq}, 32'd1);
      irq_clr = 1'b1;
      @(negedge clk);
      irq_clr = 1'b0;
      check("to_pirq_clr", {31'd0, pirq}, 32'd0);

      // Ready arrives in exactly the timeout cycle: normal completion.
      pa = 32'h30000040; prd = 1'b1;
      @(negedge clk);                       // ISSUE
      repeat (8) @(negedge clk);            // 8th WAIT cycle
      ready = 1'b1;
      spo   = 32'ha5a50001;
      @(negedge clk);                       // RESP
      ready = 1'b0;
      spo   = 32'd0;
      check("race_pirq", {31'd0, pirq}, 32'd0);
      @(negedge clk);                       // HOLD
      check("race_pready", {31'd0, pready}, 32'd1);
      check("race_pspo", pspo, 32'ha5a50001);
      check("race_err_addr", err_addr, 32'h30000000);
      @(negedge clk);
      prd = 1'b0;

      // Reset while waiting abandons the access without a pready.
      pa = 32'h40000000; prd = 1'b1;
      @(negedge clk);                       // ISSUE
      @(negedge clk);                       // WAIT
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_rd", {31'd0, rd}, 32'd0);
      check("mid_rst_err_addr", err_addr, 32'd0);
      rst = 1'b0;
      prd = 1'b0;
      pready_base = n_pready;
      repeat (4) @(negedge clk);
      check("mid_rst_no_pready", n_pready - pready_base, 32'd0);

      // prd and pwe together become a read, then two back-to-back reads.
      rd_rise_base = n_rd_rise;
      pready_base  = n_pready;
      do_read("both", 32'h50000000, 32'h0000beef, 1'b1);
      do_read("b2b0", 32'h50000100, 32'h01020304, 1'b0);
      do_read("b2b1", 32'h50000200, 32'h05060708, 1'b0);
      @(negedge clk);
      check("b2b_accesses", n_rd_rise - rd_rise_base, 32'd3);
      check("b2b_preadys", n_pready - pready_base, 32'd3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
